axil_reg_slice_cfg: RTL
=======================

// Module: axil_reg_slice_cfg
// PURPOSE
//  Parametrised AXI-Lite register slice. Each of the AW/W/B/AR/R channels is
//  independently configurable as bypass, light (bubble) or full (skid) stage.
//  Adds outstanding-transaction tracking with a per-direction cap, and a
//  decouple/quiesce handshake. Sits between a shell interconnect and a user
//  region so that region can be isolated safely.
// PARAMETERS
//  ADDR_WIDTH   32  AW/AR address width
//  DATA_WIDTH   32  W/R data width (32 or 64); WSTRB width = DATA_WIDTH/8
//  AW_MODE       2  0=bypass, 1=light, 2=full (same encoding for all *_MODE)
//  W_MODE        2  W channel mode
//  B_MODE        2  B channel mode
//  AR_MODE       2  AR channel mode
//  R_MODE        2  R channel mode
//  MAX_OUTSTAND  4  max in-flight writes and max in-flight reads (1..255)
// PORTS
//  aclk            in   1   clock; all interfaces synchronous
//  areset          in   1   asynchronous, active-high reset
//  axi_lite_s_*    -    -   slave AXI-Lite (aw/w/b/ar/r: addr,data,strb,resp,valid,ready)
//  axi_lite_m_*    -    -   master AXI-Lite, same signal set, opposite directions
//  decouple        in   1   1 = stop accepting new AW/AR transactions
//  quiesced        out  1   1 = decouple high and nothing in flight
//  protocol_err    out  1   sticky: B or R returned with no transaction outstanding
// BEHAVIOUR
//  Reset: all stage valids 0, counters 0, quiesced 0, protocol_err 0.
//   s_*ready low while areset is high (modes 1/2); mode 0 passes m_*ready through.
//  Stage modes (payload = addr | {data,strb} | resp | {resp,data}):
//   0 bypass: combinational wires, 0-cycle latency.
//   1 light: single register; in_ready = ~full; out_valid = full. Latency 1,
//     max throughput 1 beat/2 cycles. Full clears on out handshake, and in_ready
//     cannot rise in the same cycle.
//   2 full: main + skid register, 1-cycle latency, 1 beat/cycle.
//     in_ready = ~skid_valid, registered. Beat accepted while out stalled goes to
//     skid; skid drains into main on the next out handshake. Beat order is preserved.
//   All modes: payload held stable while out_valid && !out_ready.
//  Counters (width $clog2(MAX_OUTSTAND+1), counted at the slave-side handshakes):
//   aw_cnt: +1 on s AW handshake, -1 on s B handshake.
//   w_cnt:  +1 on s W handshake,  -1 on s B handshake.
//   ar_cnt: +1 on s AR handshake, -1 on s R handshake.
//   Increment and decrement in the same cycle leave the count unchanged.
//   A decrement at 0 saturates at 0 and sets protocol_err (cleared only by reset).
//  Acceptance gating (applied to s-side ready AND to valid entering the stage):
//   AW accepted iff stage ready && !decouple && aw_cnt < MAX_OUTSTAND.
//   AR accepted iff stage ready && !decouple && ar_cnt < MAX_OUTSTAND.
//   W accepted iff stage ready && w_cnt < MAX_OUTSTAND &&
//     (!decouple || w_cnt < aw_cnt). The last term means no orphan W is taken
//     once decoupled.
//   B/R channels are never gated; responses always drain.
//  Decouple asserted mid-transfer: a valid already presented but not yet
//   handshaken is not accepted; s-side valid may stay high (AXI rules are the
//   master's concern). Accepted transactions complete normally.
//  quiesced: registered; 1 cycle after decouple && aw_cnt==0 && w_cnt==0 &&
//   ar_cnt==0; falls 1 cycle after decouple deasserts.
//  Reset mid-operation: all in-flight beats are discarded, no m-side valid
//   is left asserted, counters return to 0.
// TESTING
//  1 All MODE=2, m ready=1, 8 back-to-back AW/W; awaddr 0x0..0x1C ->
//    m awvalid from cycle 1, 8 beats in 8 cycles, order and data preserved.
//  2 AW_MODE=1, 4 back-to-back AW -> m beats on cycles 1,3,5,7;
//    s_awready toggles 1,0,1,0.
//  3 MODE=2, m_arready held 0 for 5 cycles with 3 AR offered -> 2 beats held
//    (main+skid), s_arready=0 after the 2nd; release -> 0x10,0x20,0x30 in order.
//  4 MAX_OUTSTAND=2, B withheld, 3 writes -> 3rd AW not accepted (s_awready=0)
//    until the first B handshake; aw_cnt reads 2 then 1 then 2.
//  5 2 reads in flight, decouple=1 -> s_arready=0; R returns both; quiesced=1
//    exactly 1 cycle after the 2nd R handshake; decouple=0 -> quiesced=0 next cycle.
//  6 Inject m_bvalid with no write outstanding -> protocol_err=1 sticky,
//    aw_cnt stays 0; pulse areset mid-burst -> all valids 0, counters 0.

Source files
------------

// File: rtl/axil_reg_slice_cfg_if.sv
// ---------------------------------------------------------------------------
// axil_reg_slice_cfg_if
// AXI-Lite signal bundle (AW/W/B/AR/R) used on both sides of the register slice.
//   master modport : drives AW/W/AR valid+payload and B/R ready
//   slave modport  : drives AW/W/AR ready and B/R valid+payload
// Handshake: a beat transfers on a rising clock edge where valid && ready are
// both high. Payload is held stable while valid && !ready.
// ---------------------------------------------------------------------------
interface axil_reg_slice_cfg_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_reg_slice_cfg.sv
// ---------------------------------------------------------------------------
// axil_reg_slice_cfg
// AXI-Lite register slice with per-channel stage mode (0 bypass, 1 light,
// 2 full/skid), outstanding-transaction caps and a decouple/quiesce handshake.
// Ports:
//   aclk, areset      clock, asynchronous active-high reset
//   axi_lite_s        slave side (towards the shell interconnect)
//   axi_lite_m        master side (towards the user region)
//   decouple          1 = stop accepting new AW/AR (and orphan W)
//   quiesced          registered: decoupled and nothing in flight
//   protocol_err      sticky: B or R seen with nothing outstanding
//   dbg_*_cnt_o       outstanding counters, zero-extended to 8 bits
// Valid/ready: a beat moves on a clock edge with valid && ready; a stage never
// changes its output payload while out_valid && !out_ready.
// ---------------------------------------------------------------------------

// One pipeline stage; MODE selects bypass / light / full (skid) behaviour.
module axil_reg_slice_cfg_stage #(
    parameter int W    = 32,
    parameter int MODE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    generate
        if (MODE == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign in_ready_o  = out_ready_i;
            assign out_valid_o = in_valid_i;
            assign out_data_o  = in_data_i;
        end else if (MODE == 1) begin : g_light
            logic         full_q, full_d;
            logic [W-1:0] data_q, data_d;

            // Ready depends only on the register, so it cannot rise in the
            // cycle the output drains: at most one beat every two cycles.
            assign in_ready_o  = !full_q && !rst;
            assign out_valid_o = full_q;
            assign out_data_o  = data_q;

            always_comb begin
                full_d = full_q;
                data_d = data_q;
                if (full_q && out_ready_i) begin
                    full_d = 1'b0;
                end else if (in_valid_i && in_ready_o) begin
                    full_d = 1'b1;
                    data_d = in_data_i;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    full_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    full_q <= full_d;
                    data_q <= data_d;
                end
            end
        end else begin : g_full
            logic         main_valid_q, main_valid_d;
            logic         skid_valid_q, skid_valid_d;
            logic [W-1:0] main_q, main_d;
            logic [W-1:0] skid_q, skid_d;
            logic         in_fire, out_fire;

            assign in_ready_o  = !skid_valid_q && !rst;
            assign out_valid_o = main_valid_q;
            assign out_data_o  = main_q;
            assign in_fire     = in_valid_i && in_ready_o;
            assign out_fire    = main_valid_q && out_ready_i;

            // Skid holds the younger beat; it always refills main before any
            // new input is taken, which keeps beats in order.
            always_comb begin
                main_valid_d = main_valid_q;
                main_d       = main_q;
                skid_valid_d = skid_valid_q;
                skid_d       = skid_q;
                if (out_fire) begin
                    if (skid_valid_q) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end else if (in_fire) begin
                        main_d = in_data_i;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end else if (in_fire) begin
                    if (!main_valid_q) begin
                        main_valid_d = 1'b1;
                        main_d       = in_data_i;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_d       = in_data_i;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                    main_q       <= '0;
                    skid_q       <= '0;
                end else begin
                    main_valid_q <= main_valid_d;
                    skid_valid_q <= skid_valid_d;
                    main_q       <= main_d;
                    skid_q       <= skid_d;
                end
            end
        end
    endgenerate
endmodule

module axil_reg_slice_cfg #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int AW_MODE      = 2,
    parameter int W_MODE       = 2,
    parameter int B_MODE       = 2,
    parameter int AR_MODE      = 2,
    parameter int R_MODE       = 2,
    parameter int MAX_OUTSTAND = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    axil_reg_slice_cfg_if.slave         axi_lite_s,
    axil_reg_slice_cfg_if.master        axi_lite_m,
    input  logic                        decouple,
    output logic                        quiesced,
    output logic                        protocol_err,
    output logic [7:0]                  dbg_aw_cnt_o,
    output logic [7:0]                  dbg_w_cnt_o,
    output logic [7:0]                  dbg_ar_cnt_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_OUTSTAND + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTAND);

    logic [CW-1:0] aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, ar_cnt_q, ar_cnt_d;
    logic          err_q, err_d, quiesced_q, quiesced_d;
    logic          aw_ok, w_ok, ar_ok;
    logic          aw_rdy, w_rdy, ar_rdy;
    logic          aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic [DATA_WIDTH+SW-1:0] w_out;
    logic [DATA_WIDTH+1:0]    r_out;

    // Gating applies to both the s-side ready and the valid entering the
    // stage, so a blocked beat is neither acknowledged nor captured.
    assign aw_ok = !decouple && (aw_cnt_q < MAX_C);
    assign ar_ok = !decouple && (ar_cnt_q < MAX_C);
    // Once decoupled, only W beats that pair with an accepted AW get through.
    assign w_ok  = (w_cnt_q < MAX_C) && (!decouple || (w_cnt_q < aw_cnt_q));

    axil_reg_slice_cfg_stage #(.W(ADDR_WIDTH), .MODE(AW_MODE)) u_aw (
        .clk(aclk), .rst(areset),
        .in_valid_i(axi_lite_s.awvalid && aw_ok), .in_ready_o(aw_rdy),
        .in_data_i(axi_lite_s.awaddr),
        .out_valid_o(axi_lite_m.awvalid), .out_ready_i(axi_lite_m.awready),
        .out_data_o(axi_lite_m.awaddr)
    );
    assign axi_lite_s.awready = aw_rdy && aw_ok;

    axil_reg_slice_cfg_stage #(.W(DATA_WIDTH + SW), .MODE(W_MODE)) u_w (
        .clk(aclk), .rst(areset),
        .in_valid_i(axi_lite_s.wvalid && w_ok), .in_ready_o(w_rdy),
        .in_data_i({axi_lite_s.wdata, axi_lite_s.wstrb}),
        .out_valid_o(axi_lite_m.wvalid), .out_ready_i(axi_lite_m.wready),
        .out_data_o(w_out)
    );
    assign axi_lite_s.wready = w_rdy && w_ok;
    assign {axi_lite_m.wdata, axi_lite_m.wstrb} = w_out;

    axil_reg_slice_cfg_stage #(.W(2), .MODE(B_MODE)) u_b (
        .clk(aclk), .rst(areset),
        .in_valid_i(axi_lite_m.bvalid), .in_ready_o(axi_lite_m.bready),
        .in_data_i(axi_lite_m.bresp),
        .out_valid_o(axi_lite_s.bvalid), .out_ready_i(axi_lite_s.bready),
        .out_data_o(axi_lite_s.bresp)
    );

    axil_reg_slice_cfg_stage #(.W(ADDR_WIDTH), .MODE(AR_MODE)) u_ar (
        .clk(aclk), .rst(areset),
        .in_valid_i(axi_lite_s.arvalid && ar_ok), .in_ready_o(ar_rdy),
        .in_data_i(axi_lite_s.araddr),
        .out_valid_o(axi_lite_m.arvalid), .out_ready_i(axi_lite_m.arready),
        .out_data_o(axi_lite_m.araddr)
    );
    assign axi_lite_s.arready = ar_rdy && ar_ok;

    axil_reg_slice_cfg_stage #(.W(DATA_WIDTH + 2), .MODE(R_MODE)) u_r (
        .clk(aclk), .rst(areset),
        .in_valid_i(axi_lite_m.rvalid), .in_ready_o(axi_lite_m.rready),
        .in_data_i({axi_lite_m.rresp, axi_lite_m.rdata}),
        .out_valid_o(axi_lite_s.rvalid), .out_ready_i(axi_lite_s.rready),
        .out_data_o(r_out)
    );
    assign {axi_lite_s.rresp, axi_lite_s.rdata} = r_out;

    assign aw_fire = axi_lite_s.awvalid && axi_lite_s.awready;
    assign w_fire  = axi_lite_s.wvalid  && axi_lite_s.wready;
    assign b_fire  = axi_lite_s.bvalid  && axi_lite_s.bready;
    assign ar_fire = axi_lite_s.arvalid && axi_lite_s.arready;
    assign r_fire  = axi_lite_s.rvalid  && axi_lite_s.rready;

    // Simultaneous +1/-1 cancel; a lone -1 at zero saturates and flags error.
    always_comb begin
        aw_cnt_d = aw_cnt_q;
        w_cnt_d  = w_cnt_q;
        ar_cnt_d = ar_cnt_q;
        err_d    = err_q;
        if (aw_fire && !b_fire) begin
            aw_cnt_d = aw_cnt_q + CW'(1);
        end else if (b_fire && !aw_fire) begin
            if (aw_cnt_q == '0) err_d = 1'b1;
            else                aw_cnt_d = aw_cnt_q - CW'(1);
        end
        if (w_fire && !b_fire) begin
            w_cnt_d = w_cnt_q + CW'(1);
        end else if (b_fire && !w_fire) begin
            if (w_cnt_q == '0) err_d = 1'b1;
            else               w_cnt_d = w_cnt_q - CW'(1);
        end
        if (ar_fire && !r_fire) begin
            ar_cnt_d = ar_cnt_q + CW'(1);
        end else if (r_fire && !ar_fire) begin
            if (ar_cnt_q == '0) err_d = 1'b1;
            else                ar_cnt_d = ar_cnt_q - CW'(1);
        end
        quiesced_d = decouple && (aw_cnt_q == '0) && (w_cnt_q == '0) && (ar_cnt_q == '0);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_cnt_q   <= '0;
            w_cnt_q    <= '0;
            ar_cnt_q   <= '0;
            err_q      <= 1'b0;
            quiesced_q <= 1'b0;
        end else begin
            aw_cnt_q   <= aw_cnt_d;
            w_cnt_q    <= w_cnt_d;
            ar_cnt_q   <= ar_cnt_d;
            err_q      <= err_d;
            quiesced_q <= quiesced_d;
        end
    end

    assign quiesced     = quiesced_q;
    assign protocol_err = err_q;
    assign dbg_aw_cnt_o = 8'(aw_cnt_q);
    assign dbg_w_cnt_o  = 8'(w_cnt_q);
    assign dbg_ar_cnt_o = 8'(ar_cnt_q);
endmodule
